// File: rtl/day_14_rr_arbiter.sv
// Round-robin arbiter producing a registered one-hot grant for the downstream
// one-hot select mux; grants end on release, request withdrawal or hold timeout.
module day_14_rr_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       release_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       gnt_valid_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic                       timeout_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 valid_q, valid_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W:0]       cand;
  logic                 owner_req;
  logic                 hold_hit;
  logic                 grant_end;
  logic [IDX_W-1:0]     next_ptr;

  // Rotating priority scan: walk from ptr upward, lowest offset wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      cand = (IDX_W+1)'(ptr_q) + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (req_i[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    owner_req = req_i[idx_q];
    hold_hit  = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD));
    grant_end = release_i || !owner_req || hold_hit;
    next_ptr  = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_GRANT;
          gnt_d   = NUM_REQ'(1) << win_idx;
          valid_d = 1'b1;
          idx_d   = win_idx;
          cnt_d   = CNT_W'(1);
        end
      end
      S_GRANT: begin
        if (grant_end) begin
          state_d   = S_IDLE;
          gnt_d     = '0;
          valid_d   = 1'b0;
          ptr_d     = next_ptr;
          // A normal end in the same cycle takes precedence over the timeout.
          timeout_d = hold_hit && !release_i && owner_req;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = valid_q;
  assign gnt_idx_o   = idx_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_day_14_rr_arbiter.sv
// Scoreboard bench for day_14_rr_arbiter: directed cycles push the expected
// post-edge outputs; a monitor pops and compares one entry per clock edge.
module tb_day_14_rr_arbiter;

  logic       clk;
  logic       reset_n;
  logic [3:0] req_i;
  logic       release_i;
  logic [3:0] gnt_o;
  logic       gnt_valid_o;
  logic [1:0] gnt_idx_o;
  logic       timeout_o;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic armed  = 1'b0;
  logic prev_valid = 1'b0;
  int   step_no = 0;

  day_14_rr_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_i      (req_i),
    .release_i  (release_i),
    .gnt_o      (gnt_o),
    .gnt_valid_o(gnt_valid_o),
    .gnt_idx_o  (gnt_idx_o),
    .timeout_o  (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and record the outputs expected after the next edge.
  task automatic cyc(input logic rst_n, input logic [3:0] req, input logic rel,
                     input logic [3:0] egnt, input logic [1:0] eidx, input logic eto);
    exp_t e;
    @(posedge clk);
    #2;
    reset_n   = rst_n;
    req_i     = req;
    release_i = rel;
    e.gnt = egnt;
    e.idx = eidx;
    e.to  = eto;
    exp_q.push_back(e);
  endtask

  // Monitor: sample 1 time unit after each edge, before the driver moves inputs.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step_no++;
      armed = 1'b1;
      checks++;
      if (gnt_o !== e.gnt) begin
        errors++;
        $display("FAIL gnt step %0d: got %b want %b", step_no, gnt_o, e.gnt);
      end
      checks++;
      if (gnt_valid_o !== (e.gnt != 4'b0000)) begin
        errors++;
        $display("FAIL gnt_valid step %0d: got %b want %b", step_no, gnt_valid_o, e.gnt != 4'b0000);
      end
      checks++;
      if (gnt_idx_o !== e.idx) begin
        errors++;
        $display("FAIL gnt_idx step %0d: got %0d want %0d", step_no, gnt_idx_o, e.idx);
      end
      checks++;
      if (timeout_o !== e.to) begin
        errors++;
        $display("FAIL timeout step %0d: got %b want %b", step_no, timeout_o, e.to);
      end
    end
    if (armed) begin
      checks++;
      if (!$onehot0(gnt_o)) begin
        errors++;
        $display("FAIL onehot0 step %0d: got %b want one-hot or zero", step_no, gnt_o);
      end
      checks++;
      if (gnt_valid_o && (gnt_o !== (4'b0001 << gnt_idx_o))) begin
        errors++;
        $display("FAIL idx_match step %0d: got gnt %b idx %0d want gnt==1<<idx", step_no, gnt_o, gnt_idx_o);
      end
      // req_i still holds the value sampled on the edge that decided the grant.
      if (gnt_valid_o && !prev_valid) begin
        checks++;
        if (req_i[gnt_idx_o] !== 1'b1) begin
          errors++;
          $display("FAIL granted_req step %0d: got req %b idx %0d want req bit set", step_no, req_i, gnt_idx_o);
        end
      end
      prev_valid = gnt_valid_o;
    end
  end

  initial begin
    reset_n   = 1'b0;
    req_i     = 4'b0000;
    release_i = 1'b0;

    // Reset
    cyc(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // T1: idle with no requests
    for (int i = 0; i < 20; i++) cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // T2: all request, release in each grant's second cycle
    for (int k = 0; k < 5; k++) begin
      logic [1:0] kk;
      kk = 2'(k);
      cyc(1'b1, 4'b1111, 1'b0, 4'b0001 << kk, kk, 1'b0);
      cyc(1'b1, 4'b1111, 1'b0, 4'b0001 << kk, kk, 1'b0);
      cyc(1'b1, 4'b1111, 1'b1, 4'b0000,       kk, 1'b0);
    end

    // T3: single requester 2, withdraw, then ptr=3 makes requester 3 beat 0
    cyc(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
    cyc(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0);
    cyc(1'b1, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0);

    // T4: hold timeout after 8 granted cycles, then re-grant
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);
    cyc(1'b1, 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b1);
    cyc(1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // T5: reset mid-grant, pointer back to 0
    cyc(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
    cyc(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
    cyc(1'b0, 4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0);
    cyc(1'b1, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0);
    cyc(1'b1, 4'b1010, 1'b1, 4'b0000, 2'd1, 1'b0);
    // ptr is 2 here; reset must return it to 0 so requester 0 beats 3
    cyc(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
    cyc(1'b1, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // T6: release coincides with cnt==MAX_HOLD, no timeout
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
    cyc(1'b1, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0);

    // T6b: request withdrawal coincides with cnt==MAX_HOLD, no timeout
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0);

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
